// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM controller port between
// instruction fetch (port 0) and data (port 1), with tagged burst read return.
module sram_port_arbiter #(
  parameter int BURST = 4,
  parameter int BCNTW = 3
) (
  input  logic        clock,
  input  logic        rst_n,
  output logic        m0_waitrequest,
  input  logic [1:0]  m0_id,
  input  logic [29:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_writedatamask,
  output logic [31:0] m0_readdata,
  output logic [1:0]  m0_readdataid,
  output logic        m1_waitrequest,
  input  logic [1:0]  m1_id,
  input  logic [29:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_writedatamask,
  output logic [31:0] m1_readdata,
  output logic [1:0]  m1_readdataid,
  input  logic        s_waitrequest,
  output logic [1:0]  s_id,
  output logic [29:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_writedatamask,
  input  logic [31:0] s_readdata,
  input  logic [1:0]  s_readdataid
);
  logic             last;
  logic             acc;
  logic [1:0]       pend;
  logic [1:0]       rd;
  logic [1:0]       el;
  logic [1:0]       g;
  logic [1:0]       hit;
  logic [BCNTW-1:0] bcnt [2];
  logic [1:0]       sid [2];
  always_comb begin
    rd = {m1_read & ~pend[1], m0_read & ~pend[0]};
    el = rd | {m1_write, m0_write};
    g[0] = el[0] & (~el[1] | last);
    g[1] = el[1] & (~el[0] | ~last);
    s_id = g[0] ? 2'd1 : g[1] ? 2'd2 : 2'd0;
    s_address = g[1] ? m1_address : m0_address;
    s_writedata = g[1] ? m1_writedata : m0_writedata;
    s_writedatamask = g[1] ? m1_writedatamask : m0_writedatamask;
    // an eligible port that is not reading must be writing
    s_read = |(g & rd);
    s_write = |(g & ~rd);
    acc = |g & ~s_waitrequest;
    m0_waitrequest = ~g[0] | s_waitrequest;
    m1_waitrequest = ~g[1] | s_waitrequest;
    hit = {(s_readdataid == 2'd2) & pend[1], (s_readdataid == 2'd1) & pend[0]};
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
      pend <= '0;
      bcnt[0] <= '0;
      bcnt[1] <= '0;
      sid[0] <= '0;
      sid[1] <= '0;
      m0_readdata <= '0;
      m1_readdata <= '0;
      m0_readdataid <= '0;
      m1_readdataid <= '0;
    end else begin
      m0_readdataid <= hit[0] ? sid[0] : 2'd0;
      m1_readdataid <= hit[1] ? sid[1] : 2'd0;
      m0_readdata <= hit[0] ? s_readdata : m0_readdata;
      m1_readdata <= hit[1] ? s_readdata : m1_readdata;
      if (acc) last <= g[1];
      for (int i = 0; i < 2; i++)
        if (acc & g[i] & rd[i]) begin
          pend[i] <= 1'b1;
          bcnt[i] <= BCNTW'(BURST);
          sid[i] <= i ? m1_id : m0_id;
        end else if (hit[i]) begin
          bcnt[i] <= bcnt[i] - 1'b1;
          pend[i] <= bcnt[i] != BCNTW'(1);
        end
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_sram_port_arbiter;
  localparam int BURST = 4;
  logic clock = 0, rst_n = 0;
  logic [1:0] m0_id = 0, m1_id = 0, m0_readdataid, m1_readdataid, s_id, s_readdataid = 0;
  logic [29:0] m0_address = 0, m1_address = 0, s_address;
  logic m0_read = 0, m1_read = 0, m0_write = 0, m1_write = 0, m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_writedata = 0, m1_writedata = 0, m0_readdata, m1_readdata, s_writedata, s_readdata = 0;
  logic [3:0] m0_writedatamask = 0, m1_writedatamask = 0, s_writedatamask;
  logic s_waitrequest = 0, s_read, s_write;

  always #5 clock = ~clock;

  sram_port_arbiter #(.BURST(BURST), .BCNTW(3)) dut (
    .clock(clock), .rst_n(rst_n),
    .m0_waitrequest(m0_waitrequest), .m0_id(m0_id), .m0_address(m0_address), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_writedatamask(m0_writedatamask),
    .m0_readdata(m0_readdata), .m0_readdataid(m0_readdataid),
    .m1_waitrequest(m1_waitrequest), .m1_id(m1_id), .m1_address(m1_address), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_writedatamask(m1_writedatamask),
    .m1_readdata(m1_readdata), .m1_readdataid(m1_readdataid),
    .s_waitrequest(s_waitrequest), .s_id(s_id), .s_address(s_address), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_writedatamask(s_writedatamask),
    .s_readdata(s_readdata), .s_readdataid(s_readdataid)
  );

  int n_chk = 0, n_fail = 0;
  bit auto_beats = 0;
  bit m_last = 1;
  bit m_pend [2];
  int m_cnt [2];
  logic [1:0] m_sid [2];
  logic [1:0] e_rdid [2];
  logic [31:0] e_rd [2];
  int acc_q [$];
  int issued [2];
  int sent [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluated once per cycle on the falling edge, inputs are stable then.
  always @(negedge clock) begin : cmp
    logic [1:0] rq, el;
    int g, p;
    bit gr;
    if (!rst_n)
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0; m_cnt[i] = 0; m_sid[i] = '0; e_rdid[i] = '0; e_rd[i] = '0;
      end
    if (!rst_n) m_last = 1;
    rq = {m1_read & !m_pend[1], m0_read & !m_pend[0]};
    el = rq | {m1_write, m0_write};
    if (el == 2'b11) g = m_last ? 0 : 1;
    else if (el[0]) g = 0;
    else if (el[1]) g = 1;
    else g = -1;
    gr = (g == 0) ? rq[0] : (g == 1) ? rq[1] : 1'b0;
    chk("s_id", 64'(s_id), 64'(g + 1));
    chk("s_read", 64'(s_read), 64'(gr));
    chk("s_write", 64'(s_write), 64'(g >= 0 && !gr));
    if (g >= 0) begin
      chk("s_address", 64'(s_address), 64'(g ? m1_address : m0_address));
      if (!gr) begin
        chk("s_writedata", 64'(s_writedata), 64'(g ? m1_writedata : m0_writedata));
        chk("s_writedatamask", 64'(s_writedatamask), 64'(g ? m1_writedatamask : m0_writedatamask));
      end
    end
    chk("m0_waitrequest", 64'(m0_waitrequest), 64'(g != 0 || s_waitrequest));
    chk("m1_waitrequest", 64'(m1_waitrequest), 64'(g != 1 || s_waitrequest));
    chk("m0_readdataid", 64'(m0_readdataid), 64'(e_rdid[0]));
    chk("m1_readdataid", 64'(m1_readdataid), 64'(e_rdid[1]));
    chk("m0_readdata", 64'(m0_readdata), 64'(e_rd[0]));
    chk("m1_readdata", 64'(m1_readdata), 64'(e_rd[1]));
    if (rst_n) begin
      e_rdid[0] = '0;
      e_rdid[1] = '0;
      if ((s_readdataid == 2'd1 || s_readdataid == 2'd2) && m_pend[int'(s_readdataid) - 1]) begin
        p = int'(s_readdataid) - 1;
        e_rd[p] = s_readdata;
        e_rdid[p] = m_sid[p];
        m_cnt[p]--;
        if (m_cnt[p] == 0) m_pend[p] = 0;
      end
      if (g >= 0 && !s_waitrequest) begin
        m_last = (g == 1);
        acc_q.push_back(g);
        if (gr) begin
          m_pend[g] = 1;
          m_cnt[g] = BURST;
          m_sid[g] = g ? m1_id : m0_id;
          issued[g] += BURST;
        end
      end
    end
  end

  task automatic drive_beat();
    int r, p;
    bit a0, a1;
    r = $urandom_range(0, 9);
    a0 = issued[0] > sent[0];
    a1 = issued[1] > sent[1];
    s_readdataid = '0;
    if (r < 6 && (a0 || a1)) begin
      p = (a0 && a1) ? $urandom_range(0, 1) : (a0 ? 0 : 1);
      s_readdataid = 2'(p + 1);
      s_readdata = $urandom;
      sent[p]++;
    end else if (r == 9) begin
      s_readdataid = 2'd3;
      s_readdata = $urandom;
    end else if (r == 8 && !a1) begin
      s_readdataid = 2'd2;
      s_readdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (auto_beats) drive_beat();
  endtask

  initial begin
    int n;
    int p;
    repeat (3) @(posedge clock);
    #1;
    chk("reset s_id", 64'(s_id), 64'd0);
    chk("reset s_read", 64'(s_read), 64'd0);
    chk("reset m0_readdataid", 64'(m0_readdataid), 64'd0);
    chk("reset m1_readdata", 64'(m1_readdata), 64'd0);
    rst_n = 1;
    // single read burst on port 0
    m0_read = 1; m0_address = 30'h1000_0010; m0_id = 2'd2;
    #1;
    chk("A s_read", 64'(s_read), 64'd1);
    chk("A s_id", 64'(s_id), 64'd1);
    chk("A m0_waitrequest", 64'(m0_waitrequest), 64'd0);
    chk("A s_address", 64'(s_address), 64'h1000_0010);
    step();
    m0_read = 0;
    for (int k = 0; k < 4; k++) begin
      s_readdataid = 2'd1; s_readdata = 32'(32'hA0 + k);
      step();
      chk("A beat id", 64'(m0_readdataid), 64'd2);
      chk("A beat data", 64'(m0_readdata), 64'(32'hA0 + k));
      chk("A m1 quiet", 64'(m1_readdataid), 64'd0);
    end
    s_readdataid = 0;
    chk("A model pend0 clear", 64'(m_pend[0]), 64'd0);
    m0_read = 1;
    #1;
    chk("A port0 eligible again", 64'(m0_waitrequest), 64'd0);
    m0_read = 0;
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    // both ports read together, interleaved return
    m0_read = 1; m1_read = 1; m0_id = 2'd1; m1_id = 2'd3; m1_address = 30'h0200_0000;
    #1;
    chk("B first s_id", 64'(s_id), 64'd1);
    chk("B m1 held", 64'(m1_waitrequest), 64'd1);
    step();
    chk("B second s_id", 64'(s_id), 64'd2);
    chk("B m1 granted", 64'(m1_waitrequest), 64'd0);
    chk("B m0 held", 64'(m0_waitrequest), 64'd1);
    step();
    m0_read = 0; m1_read = 0;
    for (int k = 0; k < 8; k++) begin
      p = k % 2;
      s_readdataid = 2'(p + 1); s_readdata = 32'(32'hB0 + k);
      step();
      chk("B own id", 64'(p ? m1_readdataid : m0_readdataid), 64'(p ? 3 : 1));
      chk("B other id", 64'(p ? m0_readdataid : m1_readdataid), 64'd0);
      chk("B data", 64'(p ? m1_readdata : m0_readdata), 64'(32'hB0 + k));
    end
    s_readdataid = 0;
    step();
    // contention fairness: port 0 reads, port 1 writes
    acc_q.delete();
    m0_read = 1; m1_write = 1; m1_writedata = 32'hCAFE_0000; m1_writedatamask = 4'hF;
    for (int it = 0; it < 4; it++) begin
      s_waitrequest = 0;
      #1;
      chk("C port0 turn", 64'(s_id), 64'd1);
      step();
      s_waitrequest = 1;
      for (int k = 0; k < 4; k++) begin
        s_readdataid = 2'd1; s_readdata = $urandom;
        step();
      end
      s_readdataid = 0; s_waitrequest = 0;
      #1;
      chk("C port1 turn", 64'(s_id), 64'd2);
      chk("C port1 write", 64'(s_write), 64'd1);
      step();
    end
    chk("C accept count", 64'(acc_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < acc_q.size(); i++) chk("C accept order", 64'(acc_q[i]), 64'(i % 2));
    m0_read = 0; m1_write = 0;
    // pending port 0: read stalls, write still goes through
    m0_read = 1; m0_id = 2'd1;
    #1;
    chk("D first read", 64'(s_read), 64'd1);
    step();
    m0_write = 1; m0_writedata = 32'hD00D_0001; m0_writedatamask = 4'b0011;
    #1;
    chk("D s_write", 64'(s_write), 64'd1);
    chk("D s_read", 64'(s_read), 64'd0);
    chk("D mask", 64'(s_writedatamask), 64'd3);
    chk("D write accepted", 64'(m0_waitrequest), 64'd0);
    step();
    m0_write = 0;
    #1;
    chk("D read held", 64'(m0_waitrequest), 64'd1);
    chk("D no read strobe", 64'(s_read), 64'd0);
    step();
    m0_read = 0;
    for (int k = 0; k < 4; k++) begin
      s_readdataid = 2'd1; s_readdata = $urandom;
      step();
    end
    s_readdataid = 0;
    step();
    // controller stall with both ports requesting
    m0_write = 1; m1_write = 1; s_waitrequest = 1;
    n = acc_q.size();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("E stable grant", 64'(s_id), 64'd2);
      chk("E m0 wait", 64'(m0_waitrequest), 64'd1);
      chk("E m1 wait", 64'(m1_waitrequest), 64'd1);
      step();
    end
    chk("E no accepts", 64'(acc_q.size()), 64'(n));
    s_waitrequest = 0;
    step();
    m0_write = 0; m1_write = 0;
    step();
    // stray beats and reset in the middle of a burst
    chk("F model pend1 clear", 64'(m_pend[1]), 64'd0);
    s_readdataid = 2'd2; s_readdata = 32'hDEAD;
    step();
    chk("F stray tag2", 64'(m1_readdataid), 64'd0);
    s_readdataid = 2'd3;
    step();
    chk("F stray tag3 m0", 64'(m0_readdataid), 64'd0);
    chk("F stray tag3 m1", 64'(m1_readdataid), 64'd0);
    s_readdataid = 0;
    m0_read = 1; m0_id = 2'd3;
    step();
    m0_read = 0; s_readdataid = 2'd1; s_readdata = 32'hE0;
    step();
    chk("F first beat", 64'(m0_readdataid), 64'd3);
    rst_n = 0;
    step();
    chk("F in reset", 64'(m0_readdataid), 64'd0);
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("F late beat dropped", 64'(m0_readdataid), 64'd0);
    end
    s_readdataid = 0;
    chk("F model pend0 clear", 64'(m_pend[0]), 64'd0);
    m0_read = 1;
    #1;
    chk("F port0 eligible", 64'(m0_waitrequest), 64'd0);
    m0_read = 0;
    step();
    // randomized traffic
    auto_beats = 1;
    for (int c = 0; c < 3000; c++) begin
      m0_read = $urandom_range(0, 2) == 0;
      m1_read = $urandom_range(0, 2) == 0;
      m0_write = $urandom_range(0, 3) == 0;
      m1_write = $urandom_range(0, 3) == 0;
      m0_id = 2'($urandom_range(1, 3));
      m1_id = 2'($urandom_range(1, 3));
      m0_address = 30'($urandom);
      m1_address = 30'($urandom);
      m0_writedata = $urandom;
      m1_writedata = $urandom;
      m0_writedatamask = 4'($urandom);
      m1_writedatamask = 4'($urandom);
      s_waitrequest = $urandom_range(0, 4) == 0;
      rst_n = $urandom_range(0, 399) != 0;
      step();
    end
    m0_read = 0; m1_read = 0; m0_write = 0; m1_write = 0; s_waitrequest = 0; rst_n = 1;
    repeat (20) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller memory port between two requesters: port 0 is instruction fetch, port 1 is data.
- Uses the same mem_* protocol on every side: waitrequest, read/write strobes, 2-bit id, and a readdataid pulse where nonzero means a valid beat.
- Round-robin arbitration of commands; tags each read with the requester index and routes the burst beats back through a registered return path.
- Sits between the CPU memory ports and the SRAM controller.

Parameters:
- BURST, 4, read beats returned per accepted read (32-bit words); must match the controller's burst length.
- BCNTW, 3, width of the per-port beat counter; must hold BURST.

Ports:
- clock  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- m0_waitrequest / m1_waitrequest  out  1  per port: command not accepted this cycle.
- m0_id / m1_id  in  2  per port: requester read id, nonzero.
- m0_address / m1_address  in  30  per port: word address.
- m0_read / m1_read  in  1  per port: read burst request.
- m0_write / m1_write  in  1  per port: single-word write request.
- m0_writedata / m1_writedata  in  32  per port: write data.
- m0_writedatamask / m1_writedatamask  in  4  per port: byte enables, 1 = write that byte.
- m0_readdata / m1_readdata  out  32  per port: returned read beat.
- m0_readdataid / m1_readdataid  out  2  per port: beat valid, carries the port's saved id; 0 means idle.
- s_waitrequest  in  1  controller busy.
- s_id  out  2  tag to controller: 1 for port 0, 2 for port 1, 0 when idle.
- s_address  out  30  forwarded address.
- s_read  out  1  forwarded read strobe.
- s_write  out  1  forwarded write strobe.
- s_writedata  out  32  forwarded write data.
- s_writedatamask  out  4  forwarded byte enables.
- s_readdata  in  32  controller read beat.
- s_readdataid  in  2  controller beat tag.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - last=1, so port 0 wins the first conflict.
  - pend0=pend1=0, bcnt0=bcnt1=0, saved ids 0.
  - m*_readdataid=0, m*_readdata=0.
  - Combinational outputs settle to idle: s_read=s_write=0 and s_id=0.
- Eligibility: port X is eligible when (mX_read and !pendX) or mX_write. A read from a port with a burst outstanding is not eligible; only that port stalls, and its writes stay eligible.
- Grant (combinational, no state machine beyond last/pend):
  - Only one port eligible: it is granted.
  - Both eligible: grant the port != last.
  - Neither eligible: gnt=none; all s_* strobes 0 and s_id=0.
- Forwarding (combinational): s_address, s_writedata, s_writedatamask, s_read and s_write come from the granted port. When the granted port's request is a read, only s_read is asserted.
- Acceptance: a command is accepted when gnt!=none and s_waitrequest=0. mX_waitrequest = !(gnt==X) or s_waitrequest.
- On an accepted command, at the next posedge:
  - last <= X.
  - Read from port X: pendX <= 1, saved idX <= mX_id, bcntX <= BURST.
- Return path: on s_readdataid==X+1 with pendX=1:
  - mX_readdata <= s_readdata and mX_readdataid <= saved idX, registered with 1 cycle latency. The beat appears on the cycle after the controller presents it.
  - bcntX decrements; when bcntX reaches 0, pendX clears in that same update.
- Default each cycle: m*_readdataid <= 0, so the output is a one-cycle pulse.
- Simultaneous events:
  - A final beat and a new read acceptance for the same port cannot coincide, because the port is not eligible while pending.
  - A final beat for one port and an acceptance for the other are both applied in the same cycle.
- Stray beats: s_readdataid with the tag's pend flag clear, or tag 3, are dropped silently. m*_readdataid stays 0.
- Mid-operation reset: all pend/bcnt clear immediately. Beats still arriving afterward are stray and dropped.
- Fairness: under continuous contention, grants alternate 0,1,0,1 for every accepted command. A held s_waitrequest does not change the grant.
- Width rules: s_id is a fixed encoding of the port index plus 1; the master ids are never forwarded to the controller. bcnt counts down modulo its width and never wraps below 0.

Test Plan:
- Reset then port 0 read at address 0x1000_0010, id=2, s_waitrequest=0:
  - s_read=1, s_id=1, m0_waitrequest=0.
  - Controller returns 4 beats tagged 1 (0xA0..0xA3) -> m0_readdataid=2 each, one cycle later, data in order; pend0 clears after the 4th beat.
- Both ports read together:
  - Port 0 is granted first, with m1_waitrequest=1.
  - Port 1 is granted on the next accepted cycle, with s_id=2.
  - Interleaved beats tagged 1 and 2 route only to their own port.
- Port 1 issues writes continuously while port 0 issues reads continuously -> accepted commands alternate 0,1,0,1 over 8 accepts.
- Port 0 has a burst pending and issues a second read plus a write -> the read is held with m0_waitrequest=1; the write is accepted, s_write=1, mask forwarded (e.g. 4'b0011).
- s_waitrequest held 1 for 5 cycles with both ports requesting -> no acceptance, grant stable, both m*_waitrequest=1, no strobe counted.
- Stray s_readdataid=2 with pend1=0, and rst_n pulsed low mid-burst -> no m*_readdataid pulse; pend flags are 0 after reset.
